// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared encodings for the EX-stage multiply/divide unit.
//   - funct3 encodings of the RV32M operations
//   - MDU FSM state encodings (2 bits)
//   - small decode helpers used by ex_mdu
package ex_mdu_pkg;

    localparam int MduOpLen = 3;

    typedef enum logic [MduOpLen-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // op[2] selects the divide group; within it op[0] means unsigned and
    // op[1] selects the remainder.
    function automatic logic op_is_div(input logic [MduOpLen-1:0] op);
        return op[2];
    endfunction

    function automatic logic op_div_signed(input logic [MduOpLen-1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_wants_rem(input logic [MduOpLen-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative radix-2 restoring divider.
//   clk, rst   clock, async active-high reset
//   start      load pulse; the first iteration is performed on this edge
//   sign_en    treat operands as two's complement (DIV/REM)
//   dividend   XLEN-bit dividend
//   divisor    XLEN-bit divisor (never zero; handled by the parent)
//   quotient   sign-corrected quotient, valid while valid is high
//   remainder  sign-corrected remainder, valid while valid is high
//   valid      all XLEN iterations complete
// The sign fix is combinational on the final magnitudes, so the parent's
// result register edge acts as the sign-fix edge.
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sign_en,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            valid
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q;

    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [XLEN-1:0]  step_rem, step_quo, step_dvs;
    logic [XLEN:0]    shifted;
    logic             take;
    logic [XLEN-1:0]  nxt_rem, nxt_quo;

    assign a_neg = sign_en & dividend[XLEN-1];
    assign b_neg = sign_en & divisor[XLEN-1];
    assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

    always_comb begin
        step_rem = start ? '0 : rem_q;
        step_quo = start ? a_mag : quo_q;
        step_dvs = start ? b_mag : dvs_q;
        shifted  = {step_rem, step_quo[XLEN-1]};
        take     = (shifted >= {1'b0, step_dvs});
        nxt_rem  = take ? XLEN'(shifted - {1'b0, step_dvs}) : shifted[XLEN-1:0];
        nxt_quo  = {step_quo[XLEN-2:0], take};
    end

    // Counter parks at CNT_LAST when idle so no stray iterations run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= CNT_LAST;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start) begin
            rem_q     <= nxt_rem;
            quo_q     <= nxt_quo;
            dvs_q     <= b_mag;
            cnt_q     <= CNT_W'(1);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end else if (cnt_q != CNT_LAST) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign valid     = (cnt_q == CNT_LAST);
    assign quotient  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign remainder = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle RV32M multiply/divide unit in the EX stage.
//   clk, rst      clock, async active-high reset
//   start         M-op present in EX (held while stalled)
//   op            funct3 of the M-op
//   rs1, rs2      forwarded operands
//   rd_in         destination register, rd_en_in its write enable
//   flush         abort the in-flight op
//   stall_req     stall IF/ID/EX (combinational)
//   busy          FSM not idle
//   done          one-cycle result-valid pulse
//   result        result, valid while done
//   rd_addr       rd of the completed op
//   rd_enable_o   done & latched rd_en_in
//
// state | meaning
// IDLE  | waiting; accepts start & ~flush
// MUL   | multiply pipeline filling
// DIV   | divider iterating
// DONE  | result registered, done high for this cycle
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_LAT    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MduOpLen-1:0]   op,
    input  logic [XLEN-1:0]       rs1,
    input  logic [XLEN-1:0]       rs2,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  rd_en_in,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rd_enable_o
);

    localparam int PIPE_D = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
    localparam logic [1:0] MUL_CNT_INIT = 2'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e            state;
    logic                  op_rem_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rd_en_q;
    logic [1:0]            mul_cnt;

    logic                  accept, is_div, sgn, rs2_zero, ovf, special;
    logic [XLEN-1:0]       special_res;
    logic [2*XLEN-1:0]     ext_a, ext_b, product;
    logic [XLEN-1:0]       mul_res_now, mul_out;
    logic [XLEN-1:0]       mul_pipe [PIPE_D];

    logic                  div_start, div_valid;
    logic [XLEN-1:0]       div_quo, div_rem;

    assign accept   = start & ~flush & (state == ST_IDLE);
    assign is_div   = op_is_div(op);
    assign sgn      = op_div_signed(op);
    assign rs2_zero = (rs2 == '0);
    assign ovf      = sgn & (rs1 == INT_MIN) & (&rs2);
    assign special  = is_div & (rs2_zero | ovf);

    always_comb begin
        if (rs2_zero) special_res = op_wants_rem(op) ? rs1 : '1;
        else          special_res = op_wants_rem(op) ? '0 : rs1;
    end

    // MULH signs both operands, MULHSU only rs1, MULHU/MUL neither matters
    // for MUL since only the low half is kept.
    assign ext_a   = (op == OP_MULH || op == OP_MULHSU)
                     ? {{XLEN{rs1[XLEN-1]}}, rs1} : {{XLEN{1'b0}}, rs1};
    assign ext_b   = (op == OP_MULH)
                     ? {{XLEN{rs2[XLEN-1]}}, rs2} : {{XLEN{1'b0}}, rs2};
    assign product = ext_a * ext_b;
    assign mul_res_now = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    // Free-running delay line: fixed latency means the accepted op's product
    // sits at the tail exactly when the MUL counter expires.
    always_ff @(posedge clk) begin
        mul_pipe[0] <= mul_res_now;
        for (int i = 1; i < PIPE_D; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    assign mul_out = (MUL_LAT == 1) ? mul_res_now : mul_pipe[PIPE_D-1];

    assign div_start = accept & is_div & ~special;

    mdu_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .sign_en   (sgn),
        .dividend  (rs1),
        .divisor   (rs2),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_rem_q    <= 1'b0;
            rd_q        <= '0;
            rd_en_q     <= 1'b0;
            mul_cnt     <= '0;
            done        <= 1'b0;
            result      <= '0;
            rd_addr     <= '0;
            rd_enable_o <= 1'b0;
        end else begin
            done        <= 1'b0;
            rd_enable_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_rem_q <= op_wants_rem(op);
                        rd_q     <= rd_in;
                        rd_en_q  <= rd_en_in;
                        if (!is_div) begin
                            if (MUL_LAT == 1) begin
                                state       <= ST_DONE;
                                done        <= 1'b1;
                                result      <= mul_res_now;
                                rd_addr     <= rd_in;
                                rd_enable_o <= rd_en_in;
                            end else begin
                                state   <= ST_MUL;
                                mul_cnt <= MUL_CNT_INIT;
                            end
                        end else if (special) begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            result      <= special_res;
                            rd_addr     <= rd_in;
                            rd_enable_o <= rd_en_in;
                        end else begin
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (mul_cnt == '0) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        result      <= mul_out;
                        rd_addr     <= rd_q;
                        rd_enable_o <= rd_en_q;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (div_valid) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        result      <= op_rem_q ? div_rem : div_quo;
                        rd_addr     <= rd_q;
                        rd_enable_o <= rd_en_q;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // rst gates stall_req so every output is low as soon as reset asserts,
    // even with start still high from the stalled instruction.
    assign stall_req = ~rst & ((start & (state == ST_IDLE) & ~flush)
                               | (state == ST_MUL) | (state == ST_DIV));
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_in;
    logic        rd_en_in;
    logic        flush;
    logic        stall_req, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        rd_enable_o;

    int total = 0;
    int bad   = 0;

    ex_mdu #(.XLEN(32), .MUL_LAT(2), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd_in       (rd_in),
        .rd_en_in    (rd_en_in),
        .flush       (flush),
        .stall_req   (stall_req),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .rd_addr     (rd_addr),
        .rd_enable_o (rd_enable_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op, hold start while stalled, then keep it through the done
    // cycle (same instruction still in EX) and drop it after.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic rden,
                          input logic [31:0] exp, input int lat);
        int   cyc;
        int   stalls;
        logic seen;
        op = o; rs1 = a; rs2 = b; rd_in = rd; rd_en_in = rden; start = 1'b1;
        #1;
        stalls = stall_req ? 1 : 0;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (stall_req) stalls++;
            if (done) seen = 1'b1;
            else check({tag, ".rd_en_low"}, 32'(rd_enable_o), 32'd0);
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(lat));
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(lat));
        check({tag, ".result"}, result, exp);
        check({tag, ".rd_addr"}, 32'(rd_addr), 32'(rd));
        check({tag, ".rd_enable"}, 32'(rd_enable_o), 32'(rden));
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
        check({tag, ".done_cleared"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;
        rd_in = '0; rd_en_in = 1'b0; flush = 1'b0;
        #1;
        check("reset.stall_req", 32'(stall_req), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.rd_addr", 32'(rd_addr), 32'd0);
        check("reset.rd_enable", 32'(rd_enable_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_7_m3",  3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3,  1'b1, 32'hFFFF_FFEB, 2);
        run_op("mulhu_ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  1'b1, 32'hFFFF_FFFE, 2);
        run_op("mulh_ff",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  1'b1, 32'h0000_0000, 2);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  1'b0, 32'hFFFF_FFFF, 2);
        run_op("mul_ff",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  1'b1, 32'h0000_0001, 2);

        run_op("div_m20_3",  3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10, 1'b1, 32'hFFFF_FFFA, 33);
        run_op("rem_m20_3",  3'd6, 32'hFFFF_FFEC, 32'd3, 5'd11, 1'b1, 32'hFFFF_FFFE, 33);
        run_op("remu_20_3",  3'd7, 32'd20,        32'd3, 5'd12, 1'b1, 32'd2,         33);

        run_op("divu_by0",  3'd5, 32'h0000_1234, 32'd0,         5'd13, 1'b1, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",   3'd6, 32'h0000_1234, 32'd0,         5'd14, 1'b1, 32'h0000_1234, 1);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h8000_0000, 1);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'h0000_0000, 1);

        // Flush a divide after ten iterations.
        op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd_in = 5'd17; rd_en_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        check("flush.busy_before", 32'(busy), 32'd1);
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.busy_after", 32'(busy), 32'd0);
        check("flush.no_done", 32'(done), 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            check("flush.quiet_done", 32'(done), 32'd0);
        end
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd21, 1'b1, 32'd12, 2);

        // Asynchronous reset in the middle of a divide.
        op = 3'd4; rs1 = 32'd20; rs2 = 32'd3; rd_in = 5'd9; rd_en_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        check("arst.busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1; start = 1'b0;
        #1;
        check("arst.stall_req", 32'(stall_req), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        check("arst.result", result, 32'd0);
        check("arst.rd_addr", 32'(rd_addr), 32'd0);
        check("arst.rd_enable", 32'(rd_enable_o), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd22, 1'b1, 32'd14, 33);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd23, 1'b1, 32'd2,  33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
